// File: rtl/hs32_alu_seq.sv
// HS32 handshaked ALU: single-cycle arithmetic/logic/shift ops plus an
// iterative shift-add multiply, with valid/ready on both request and result.
module hs32_alu_seq #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       fl_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] r_o,
  output logic [3:0]       fl_o
);
  localparam logic [3:0] OP_MOV = 4'd0,  OP_ADD = 4'd1,  OP_SUB = 4'd2,  OP_ADC = 4'd3;
  localparam logic [3:0] OP_SBC = 4'd4,  OP_AND = 4'd5,  OP_OR  = 4'd6,  OP_XOR = 4'd7;
  localparam logic [3:0] OP_BIC = 4'd8,  OP_LSL = 4'd9,  OP_LSR = 4'd10, OP_ASR = 4'd11;
  localparam logic [3:0] OP_ROR = 4'd12, OP_MUL = 4'd13;
  localparam logic [SHW:0] LAST = (SHW+1)'(WIDTH-1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  state_t state, state_n;

  logic [SHW:0]       cnt;
  logic [WIDTH-1:0]   acc, mcand, mplier, acc_nxt;
  logic [1:0]         cv_q;
  logic               accept;

  assign ready_o = (state == S_IDLE) && !reset;
  assign valid_o = (state == S_DONE);
  assign accept  = valid_i && ready_o;

  // Single-cycle datapath, evaluated directly on the request inputs
  logic [SHW-1:0]      n;
  logic                is_sub, cin, c, v;
  logic [WIDTH-1:0]    bx, res;
  logic [WIDTH:0]      sum, lsl_t, lsr_t;
  logic signed [WIDTH:0] asr_t;
  logic [WIDTH-1:0]    ror_r;

  assign n      = b_i[SHW-1:0];
  assign is_sub = (op_i == OP_SUB) || (op_i == OP_SBC);
  assign bx     = is_sub ? ~b_i : b_i;
  assign cin    = (op_i == OP_SUB) ? 1'b1 :
                  ((op_i == OP_ADC) || (op_i == OP_SBC)) ? fl_i[1] : 1'b0;
  assign sum    = {1'b0, a_i} + {1'b0, bx} + {{WIDTH{1'b0}}, cin};
  // Extra bit on each shifter catches the last bit shifted out
  assign lsl_t  = {1'b0, a_i} << n;
  assign lsr_t  = {a_i, 1'b0} >> n;
  assign asr_t  = $signed({a_i, 1'b0}) >>> n;
  assign ror_r  = (a_i >> n) | (a_i << ((SHW+1)'(WIDTH) - {1'b0, n}));

  always_comb begin
    res = b_i;
    c   = fl_i[1];
    v   = fl_i[0];
    case (op_i)
      OP_ADD, OP_ADC: begin
        res = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        v   = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (res[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_SUB, OP_SBC: begin
        res = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        v   = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (res[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_AND: res = a_i & b_i;
      OP_OR:  res = a_i | b_i;
      OP_XOR: res = a_i ^ b_i;
      OP_BIC: res = a_i & ~b_i;
      OP_LSL: begin
        res = lsl_t[WIDTH-1:0];
        if (n != '0) c = lsl_t[WIDTH];
      end
      OP_LSR: begin
        res = lsr_t[WIDTH:1];
        if (n != '0) c = lsr_t[0];
      end
      OP_ASR: begin
        res = asr_t[WIDTH:1];
        if (n != '0) c = asr_t[0];
      end
      OP_ROR: begin
        res = ror_r;
        if (n != '0) c = ror_r[WIDTH-1];
      end
      default: res = b_i;
    endcase
  end

  assign acc_nxt = acc + (mplier[0] ? mcand : '0);

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (accept) state_n = (op_i == OP_MUL) ? S_BUSY : S_DONE;
      S_BUSY: if (cnt == LAST) state_n = S_DONE;
      S_DONE: if (ready_i) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      r_o    <= '0;
      fl_o   <= '0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cv_q   <= '0;
    end else begin
      state <= state_n;
      case (state)
        S_IDLE: if (accept) begin
          if (op_i == OP_MUL) begin
            acc    <= '0;
            mcand  <= a_i;
            mplier <= b_i;
            cv_q   <= fl_i[1:0];
            cnt    <= '0;
          end else begin
            r_o  <= res;
            fl_o <= {res[WIDTH-1], res == '0, c, v};
          end
        end
        S_BUSY: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            r_o  <= acc_nxt;
            fl_o <= {acc_nxt[WIDTH-1], acc_nxt == '0, cv_q};
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/hs32_alu_seq.md
Name: hs32_alu_seq

Overview:
Parametrised, handshaked successor to the HS32 single-cycle ALU.
- Width-generic datapath.
- Full NZCV semantics, including true signed overflow.
- Carry-in ops, logic ops and barrel shifts.
- Iterative multi-cycle unsigned multiply.
- Sits between the decode/register-read stage and writeback. Uses valid/ready on both sides so the pipeline stalls during multi-cycle ops.

Parameters:
WIDTH, 32, datapath width. Power of two, >= 8.
SHW, $clog2(WIDTH), derived shift-amount width. Not to be overridden.

Ports:
clk  in  1  clock; all logic is rising-edge.
reset  in  1  synchronous, active-high reset.
valid_i  in  1  request valid.
ready_o  out  1  block can accept a request.
op_i  in  4  operation code.
a_i  in  WIDTH  operand A.
b_i  in  WIDTH  operand B (shift amount = b_i[SHW-1:0]).
fl_i  in  4  current flags nzcv, bits [3:0] = N,Z,C,V.
valid_o  out  1  result valid.
ready_i  in  1  consumer accepts result.
r_o  out  WIDTH  registered result.
fl_o  out  4  registered flags nzcv.

Behaviour:
- Op codes:
  - 0 MOV (r=b), 1 ADD, 2 SUB, 3 ADC (a+b+C), 4 SBC (a-b-!C).
  - 5 AND, 6 OR, 7 XOR, 8 BIC (a&~b).
  - 9 LSL, 10 LSR, 11 ASR, 12 ROR (a shifted by b[SHW-1:0]).
  - 13 MUL (low WIDTH bits of unsigned a*b).
  - 14, 15 reserved: behave as MOV.
- Capture: op, a, b and fl_i are captured on accept (valid_i && ready_o). Inputs are don't-care otherwise.
- States:
  - IDLE: ready_o=1.
    - Accept of a non-MUL op: compute, register r_o/fl_o, go to DONE.
    - Accept of MUL: go to BUSY.
  - BUSY: shift-add multiply, one multiplier bit per cycle. A SHW+1-bit counter runs 0..WIDTH-1. After WIDTH cycles, register the result and go to DONE.
  - DONE: valid_o=1. Go to IDLE on ready_i.
- ready_o: equals (state==IDLE) && !reset. It is low in BUSY and DONE, so no accept occurs in the same cycle as result hand-off; single-op throughput is one result per 2 cycles.
- Latency:
  - Non-MUL: valid_o high in the cycle after accept.
  - MUL: valid_o high WIDTH+1 cycles after accept.
- Backpressure: r_o, fl_o and valid_o are held stable in DONE while ready_i=0.
- Flags:
  - All ops: N=r[WIDTH-1], Z=(r==0).
  - ADD/ADC: C=carry-out of bit WIDTH-1. V=(a[MSB]==b[MSB]) && (r[MSB]!=a[MSB]).
  - SUB/SBC: C=NOT borrow (1 when no borrow). V=(a[MSB]!=b[MSB]) && (r[MSB]!=a[MSB]).
  - Logic ops, MOV, reserved: C and V copied from the captured fl_i.
  - Shifts, amount n>0:
    - C = last bit shifted out: LSL a[WIDTH-n]; LSR/ASR/ROR a[n-1].
    - For ROR, C equals r[MSB].
    - V copied from fl_i.
  - Shifts, n=0: r=a, C and V from fl_i.
  - MUL: C and V from fl_i.
- Arithmetic: modulo 2^WIDTH, using a WIDTH+1-bit internal adder for carry.
- ASR sign-fills from a[MSB].
- Reset: any state, including mid-MUL, goes to IDLE next edge. r_o=0, fl_o=0, valid_o=0, counter=0, and the partial product is discarded.
- After deassert of reset, ready_o=1 in the first non-reset cycle.
- valid_i while ready_o=0 is ignored and not queued.

Test Plan (WIDTH=32):
1. ADD a=0xFFFFFFFF b=1 -> r_o=0, fl_o=0110, valid_o one cycle after accept. Then ADC a=0xFFFFFFFF b=0 fl_i=0010 -> r_o=0, fl_o=0110.
2. SUB a=0x80000000 b=1 -> r_o=0x7FFFFFFF, fl_o=0011. SUB a=0 b=1 -> r_o=0xFFFFFFFF, fl_o=1000.
3. MUL a=0x00010001 b=0x00010001 fl_i=0011 -> ready_o low for 33 cycles, valid_o at accept+33, r_o=0x00020001, fl_o=0011.
4. Backpressure: after AND a=0xF0 b=0x3C, hold ready_i=0 for 5 cycles -> r_o=0x30 and fl_o stable, valid_o=1, ready_o=0. valid_i pulses in these cycles are ignored. Release -> IDLE next cycle.
5. Shifts:
   - LSR a=3 b=1 fl_i=0000 -> r_o=1, fl_o=0010.
   - ASR a=0x80000000 b=31 -> r_o=0xFFFFFFFF, fl_o=1000.
   - ROR a=1 b=1 -> r_o=0x80000000, fl_o=1010.
   - LSL b=0 fl_i=0011 -> r_o=a, C=1, V=1.
6. Reset at MUL cycle 10 -> next cycle valid_o=0, r_o=0, fl_o=0, ready_o=1. A following ADD 2+3 -> r_o=5, fl_o=0000.
